uart_rx_param: RTL

- Parametrised UART receiver for the pipelined CPU's serial peripheral port.
- Successor to the fixed 8N1, 9600-baud receiver: configurable clock and baud rate, data width, parity and stop bits.
- Adds oversampled majority-vote sampling, per-word error flags, a small receive FIFO with valid/ready handshake, and sticky overrun.
- Sits between the board RX pin and the CPU's memory-mapped UART registers.

---
 rtl/uart_pkg.sv | 55 +++++
 rtl/uart_rx_fifo.sv | 58 +++++
 rtl/uart_rx_param.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and elaboration helpers for the UART receiver.
// Revision    : 1.0 - initial parametrised receiver release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PAR     = 3'd3,
        ST_STOP    = 3'd4,
        ST_WAIT_HI = 3'd5
    } rx_state_e;

    localparam int c_MIN_OVERSAMPLE = 8;
    localparam int c_MIN_DATA_BITS  = 5;
    localparam int c_MAX_DATA_BITS  = 9;

    function automatic bit rx_params_ok(
        input int oversample,
        input int data_bits,
        input int parity,
        input int stop_bits,
        input int fifo_depth
    );
        bit ok;
        ok = (oversample >= c_MIN_OVERSAMPLE) && (oversample % 2 == 0);
        ok = ok && (data_bits >= c_MIN_DATA_BITS) && (data_bits <= c_MAX_DATA_BITS);
        ok = ok && (parity >= int'(PAR_NONE)) && (parity <= int'(PAR_EVEN));
        ok = ok && (stop_bits == 1 || stop_bits == 2);
        ok = ok && (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0);
        return ok;
    endfunction

    // Rounded clock divider per oversample tick; 0 flags an unusable rate.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        int tick_hz;
        if (baud <= 0 || oversample < c_MIN_OVERSAMPLE || clk_hz <= 0) begin
            return 0;
        end
        tick_hz = baud * oversample;
        return (clk_hz + tick_hz / 2) / tick_hz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Show-ahead receive FIFO; head word is visible on rdata.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int c_AW = $clog2(DEPTH);

    // Extra MSB on each pointer separates full from empty.
    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_rd_en;
    logic               w_wr_en;

    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_rd_en = pop && !empty;
    assign w_wr_en = push && (!full || w_rd_en);
    assign rdata   = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= wdata;
                r_wr_ptr                  <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Oversampled, majority-voting UART receiver with error flags,
//               show-ahead receive FIFO and sticky overrun.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 din,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun,
    input  logic                 clr_overrun,
    output logic                 busy
);

    localparam int c_DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_OS_W  = $clog2(OVERSAMPLE);
    localparam int c_BIT_W = $clog2(DATA_BITS);
    localparam int c_WORD_W = DATA_BITS + 2;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);
    localparam logic [c_OS_W-1:0]  c_OS_LAST  = c_OS_W'(OVERSAMPLE - 1);
    localparam logic [c_OS_W-1:0]  c_S0       = c_OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_OS_W-1:0]  c_S1       = c_OS_W'(OVERSAMPLE / 2);
    localparam logic [c_OS_W-1:0]  c_S2       = c_OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_BITS - 1);
    localparam logic               c_STOP_LAST = (STOP_BITS == 2);
    localparam bit                 c_PAR_EN    = (PARITY != int'(PAR_NONE));
    localparam bit                 c_PAR_ODD   = (PARITY == int'(PAR_ODD));

    generate
        if (!rx_params_ok(OVERSAMPLE, DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH) || c_DIV < 1)
        begin : g_param_check
            $error("uart_rx_param: illegal parameter combination");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input synchroniser and edge history
    // ------------------------------------------------------------------
    logic [1:0] r_sync;
    logic       r_ds_prev;
    logic       w_ds;

    assign w_ds = r_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync    <= 2'b11;
            r_ds_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], din};
            r_ds_prev <= w_ds;
        end
    end

    // ------------------------------------------------------------------
    // Tick generator and majority-vote sampler
    // ------------------------------------------------------------------
    rx_state_e          r_state;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_OS_W-1:0]  r_os_cnt;
    logic               r_s0;
    logic               r_s1;
    logic               w_start;
    logic               w_tick;
    logic               w_vote_en;
    logic               w_vote;

    assign w_start   = (r_state == ST_IDLE) && r_ds_prev && !w_ds;
    assign w_tick    = (r_div_cnt == c_DIV_LAST);
    assign w_vote_en = w_tick && (r_os_cnt == c_S2);
    assign w_vote    = (r_s0 & r_s1) | (r_s0 & w_ds) | (r_s1 & w_ds);

    // Restarting on the start edge aligns every later bit's sample window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_cnt <= '0;
            r_os_cnt  <= '0;
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
        end else begin
            if (w_start) begin
                r_div_cnt <= '0;
                r_os_cnt  <= '0;
            end else if (w_tick) begin
                r_div_cnt <= '0;
                r_os_cnt  <= (r_os_cnt == c_OS_LAST) ? '0 : r_os_cnt + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            if (w_tick && r_os_cnt == c_S0) begin
                r_s0 <= w_ds;
            end
            if (w_tick && r_os_cnt == c_S1) begin
                r_s1 <= w_ds;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_stop_cnt;
    logic                 r_busy;
    logic                 w_exp_par;
    logic                 w_push;
    logic [c_WORD_W-1:0]  w_wdata;

    assign w_exp_par = c_PAR_ODD ? ~(^r_shift) : (^r_shift);
    assign w_push    = w_vote_en && (r_state == ST_STOP) && (r_stop_cnt == c_STOP_LAST);
    // The final stop vote is folded in here since r_ferr updates one edge later.
    assign w_wdata   = {r_ferr | ~w_vote, r_perr, r_shift};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_vote_en) begin
                        if (w_vote) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= ST_DATA;
                            r_bit_cnt  <= '0;
                            r_perr     <= 1'b0;
                            r_ferr     <= 1'b0;
                            r_stop_cnt <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_vote_en) begin
                        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == c_BIT_LAST) begin
                            r_state <= c_PAR_EN ? ST_PAR : ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PAR: begin
                    if (w_vote_en) begin
                        r_perr  <= (w_vote != w_exp_par);
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_vote_en) begin
                        if (!w_vote) begin
                            r_ferr <= 1'b1;
                        end
                        if (r_stop_cnt == c_STOP_LAST) begin
                            if (w_vote) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= ST_WAIT_HI;
                            end
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end
                ST_WAIT_HI: begin
                    if (w_ds) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO and overrun
    // ------------------------------------------------------------------
    logic [c_WORD_W-1:0] w_rdata;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_drop;
    logic                r_overrun;

    assign w_pop  = rx_ready && !w_empty;
    assign w_drop = w_push && w_full && !w_pop;

    uart_rx_fifo #(
        .WIDTH (c_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .wdata (w_wdata),
        .pop   (w_pop),
        .rdata (w_rdata),
        .empty (w_empty),
        .full  (w_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign rx_data       = w_rdata[DATA_BITS-1:0];
    assign rx_parity_err = w_rdata[DATA_BITS];
    assign rx_frame_err  = w_rdata[DATA_BITS+1];
    assign rx_valid      = !w_empty;
    assign overrun       = r_overrun;
    assign busy          = r_busy;

endmodule
`default_nettype wire
